// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST session controller.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_END,
        GAP,
        DONE
    } bist_state_e;

    localparam int unsigned BIST_SIG_W = 16;
    localparam logic [BIST_SIG_W-1:0] BIST_GOLDEN = 16'h0000;

endpackage

// File: rtl/bist_run_timer.sv
// Loadable down-counter with a zero flag; times the START, WAIT_END and GAP intervals.
module bist_run_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/bist_session_ctrl.sv
// BIST session initiator: pulses bist_start, captures each run's result, repeats NRUNS times.
// Optional BIST_CONSISTENCY_CHECK_EN: also fails runs whose signature differs from the first run.
module bist_session_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned     SIG_W     = BIST_SIG_W,
    parameter int unsigned     NRUNS     = 5,
    parameter int unsigned     START_CYC = 3,
    parameter int unsigned     GAP_CYC   = 10,
    parameter int unsigned     TIMEOUT   = 4096,
    parameter logic [SIG_W-1:0] GOLDEN   = SIG_W'(BIST_GOLDEN)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    output logic                         bist_start,
    input  logic                         bist_end,
    input  logic                         pass_fail,
    input  logic [SIG_W-1:0]             signature_in,
    output logic                         busy,
    output logic                         done,
    output logic                         session_pass,
    output logic [$clog2(NRUNS+1)-1:0]   run_count,
    output logic [$clog2(NRUNS+1)-1:0]   fail_count,
    output logic [SIG_W-1:0]             last_signature,
`ifdef BIST_CONSISTENCY_CHECK_EN
    output logic                         sig_mismatch,
`endif
    output logic                         timeout_err
);

    localparam int unsigned CNT_W  = $clog2(NRUNS + 1);
    localparam int unsigned T_MAX0 = (TIMEOUT > START_CYC) ? TIMEOUT : START_CYC;
    localparam int unsigned T_MAX  = (T_MAX0 > GAP_CYC) ? T_MAX0 : GAP_CYC;
    localparam int unsigned TMR_W  = $clog2(T_MAX + 1);

    // Timer is loaded with N-1 so each interval lasts exactly N cycles.
    localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(NRUNS);

    bist_state_e        state, state_d;
    logic               bist_end_q;
    logic               end_rise;
    logic               run_fail;
    logic               bist_start_d, busy_d, done_d, session_pass_d, timeout_d;
    logic [CNT_W-1:0]   run_count_d, fail_count_d;
    logic [SIG_W-1:0]   last_sig_d;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;

`ifdef BIST_CONSISTENCY_CHECK_EN
    logic [SIG_W-1:0]   reference_sig, reference_sig_d;
    logic               sig_mismatch_d;
    logic               ref_diff;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    bist_run_timer #(.W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero)
    );

    assign end_rise = bist_end && !bist_end_q;

`ifdef BIST_CONSISTENCY_CHECK_EN
    assign ref_diff = (run_count != '0) && (signature_in != reference_sig);
    assign run_fail = (signature_in != GOLDEN) || !pass_fail || ref_diff;
`else
    assign run_fail = (signature_in != GOLDEN) || !pass_fail;
`endif

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bist_end_q     <= 1'b0;
            bist_start     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            session_pass   <= 1'b0;
            run_count      <= '0;
            fail_count     <= '0;
            last_signature <= '0;
            timeout_err    <= 1'b0;
`ifdef BIST_CONSISTENCY_CHECK_EN
            reference_sig  <= '0;
            sig_mismatch   <= 1'b0;
`endif
        end else begin
            state          <= state_d;
            bist_end_q     <= bist_end;
            bist_start     <= bist_start_d;
            busy           <= busy_d;
            done           <= done_d;
            session_pass   <= session_pass_d;
            run_count      <= run_count_d;
            fail_count     <= fail_count_d;
            last_signature <= last_sig_d;
            timeout_err    <= timeout_d;
`ifdef BIST_CONSISTENCY_CHECK_EN
            reference_sig  <= reference_sig_d;
            sig_mismatch   <= sig_mismatch_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state;
        bist_start_d   = bist_start;
        busy_d         = busy;
        done_d         = done;
        session_pass_d = session_pass;
        run_count_d    = run_count;
        fail_count_d   = fail_count;
        last_sig_d     = last_signature;
        timeout_d      = timeout_err;
        tmr_load       = 1'b0;
        tmr_val        = '0;
        tmr_dec        = 1'b0;
`ifdef BIST_CONSISTENCY_CHECK_EN
        reference_sig_d = reference_sig;
        sig_mismatch_d  = sig_mismatch;
`endif

        case (state)
            IDLE, DONE: begin
                if (go) begin
                    state_d        = START;
                    bist_start_d   = 1'b1;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    session_pass_d = 1'b0;
                    run_count_d    = '0;
                    fail_count_d   = '0;
                    timeout_d      = 1'b0;
                    tmr_load       = 1'b1;
                    tmr_val        = START_LOAD;
`ifdef BIST_CONSISTENCY_CHECK_EN
                    sig_mismatch_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tmr_zero) begin
                    state_d      = WAIT_END;
                    bist_start_d = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_val      = TIMEOUT_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            WAIT_END: begin
                // A completion edge wins over a timer expiring in the same cycle.
                if (end_rise) begin
                    state_d     = GAP;
                    last_sig_d  = signature_in;
                    run_count_d = sat_inc(run_count);
                    if (run_fail) begin
                        fail_count_d = sat_inc(fail_count);
                    end
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
`ifdef BIST_CONSISTENCY_CHECK_EN
                    if (run_count == '0) begin
                        reference_sig_d = signature_in;
                    end else if (ref_diff) begin
                        sig_mismatch_d = 1'b1;
                    end
`endif
                end else if (tmr_zero) begin
                    state_d        = DONE;
                    timeout_d      = 1'b1;
                    run_count_d    = sat_inc(run_count);
                    fail_count_d   = sat_inc(fail_count);
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    session_pass_d = 1'b0;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else if (run_count >= CNT_MAX) begin
                    state_d        = DONE;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                    session_pass_d = (fail_count == '0) && !timeout_err;
                end else begin
                    state_d      = START;
                    bist_start_d = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_val      = START_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Directed bench for bist_session_ctrl; define BIST_CONSISTENCY_CHECK_EN to exercise the reference check.
module tb_bist_session_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic        bist_start;
    logic        bist_end = 1'b0;
    logic        pass_fail = 1'b0;
    logic [15:0] signature_in = 16'h0000;
    logic        busy, done, session_pass, timeout_err;
    logic [1:0]  run_count, fail_count;
    logic [15:0] last_signature;
`ifdef BIST_CONSISTENCY_CHECK_EN
    logic        sig_mismatch;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int pulses   = 0;
    logic start_prev = 1'b0;

    always #5 clock = ~clock;

    bist_session_ctrl #(
        .SIG_W     (16),
        .NRUNS     (3),
        .START_CYC (3),
        .GAP_CYC   (10),
        .TIMEOUT   (50),
        .GOLDEN    (16'hA5C3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .go             (go),
        .bist_start     (bist_start),
        .bist_end       (bist_end),
        .pass_fail      (pass_fail),
        .signature_in   (signature_in),
        .busy           (busy),
        .done           (done),
        .session_pass   (session_pass),
        .run_count      (run_count),
        .fail_count     (fail_count),
        .last_signature (last_signature),
`ifdef BIST_CONSISTENCY_CHECK_EN
        .sig_mismatch   (sig_mismatch),
`endif
        .timeout_err    (timeout_err)
    );

    // Count bist_start pulses seen at negedges.
    always @(negedge clock) begin
        start_prev <= bist_start;
        if (bist_start && !start_prev) pulses <= pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_go();
        @(negedge clock); go = 1'b1;
        @(negedge clock); go = 1'b0;
    endtask

    // Wait for a bist_start pulse and measure its width; returns on the first low negedge.
    task automatic wait_pulse();
        int n = 0;
        int width = 0;
        while (!bist_start && n < 200) begin
            @(negedge clock); n++;
        end
        if (n >= 200) begin
            check("start_seen", 32'(bist_start), 32'd1);
            return;
        end
        while (bist_start && width < 20) begin
            width++;
            @(negedge clock);
        end
        check("start_width", 32'(width), 32'd3);
    endtask

    // Answer one run: bist_end pulse 20 cycles after bist_start falls.
    task automatic respond(input logic [15:0] sig, input logic pf);
        wait_pulse();
        bist_end = 1'b0;
        repeat (19) @(negedge clock);
        bist_end = 1'b1; signature_in = sig; pass_fail = pf;
        @(negedge clock);
        bist_end = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clock); n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_start"}, 32'(bist_start), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(session_pass), 32'd0);
        check({tag, "_runs"},  32'(run_count), 32'd0);
        check({tag, "_fails"}, 32'(fail_count), 32'd0);
        check({tag, "_sig"},   32'(last_signature), 32'd0);
        check({tag, "_tmo"},   32'(timeout_err), 32'd0);
    endtask

    initial begin
        int p0;
        int n;

        #12;
        check_cleared("reset");
        @(negedge clock); reset = 1'b1;

        // 1: three good runs
        p0 = pulses;
        pulse_go();
        check("t1_start_after_go", 32'(bist_start), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (3) respond(16'hA5C3, 1'b1);
        wait_done();
        check("t1_pass", 32'(session_pass), 32'd1);
        check("t1_runs", 32'(run_count), 32'd3);
        check("t1_fails", 32'(fail_count), 32'd0);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_pulses", 32'(pulses - p0), 32'd3);

        // 2: second run bad signature
        pulse_go();
        check("t2_done_cleared", 32'(done), 32'd0);
        respond(16'hA5C3, 1'b1);
        respond(16'hA5C2, 1'b1);
        respond(16'hA5C3, 1'b1);
        wait_done();
        check("t2_fails", 32'(fail_count), 32'd1);
        check("t2_pass", 32'(session_pass), 32'd0);
        check("t2_last_sig", 32'(last_signature), 32'h0000A5C3);

        // 2b: golden signature but pass_fail low on the last run
        pulse_go();
        respond(16'hA5C3, 1'b1);
        respond(16'hA5C3, 1'b1);
        respond(16'hA5C3, 1'b0);
        wait_done();
        check("t2b_fails", 32'(fail_count), 32'd1);
        check("t2b_pass", 32'(session_pass), 32'd0);

        // 3: no bist_end ever -> timeout after exactly 50 WAIT_END cycles
        p0 = pulses;
        pulse_go();
        wait_pulse();
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clock); n++;
        end
        check("t3_timeout_cycle", 32'(n), 32'd50);
        check("t3_tmo", 32'(timeout_err), 32'd1);
        check("t3_done", 32'(done), 32'd1);
        check("t3_runs", 32'(run_count), 32'd1);
        check("t3_fails", 32'(fail_count), 32'd1);
        check("t3_pass", 32'(session_pass), 32'd0);
        repeat (30) @(negedge clock);
        check("t3_pulses", 32'(pulses - p0), 32'd1);

        // 4: stale-high bist_end is not a completion; a fresh edge is
        bist_end = 1'b1; signature_in = 16'hA5C3; pass_fail = 1'b1;
        pulse_go();
        check("t4_tmo_cleared", 32'(timeout_err), 32'd0);
        wait_pulse();
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clock); n++;
        end
        check("t4_stale_timeout", 32'(n), 32'd50);
        check("t4_stale_runs", 32'(run_count), 32'd1);
        pulse_go();
        wait_pulse();
        repeat (5) @(negedge clock);
        bist_end = 1'b0;
        @(negedge clock); bist_end = 1'b1;
        @(negedge clock);
        check("t4_edge_runs", 32'(run_count), 32'd1);
        check("t4_edge_tmo", 32'(timeout_err), 32'd0);
        check("t4_edge_busy", 32'(busy), 32'd1);
        repeat (2) respond(16'hA5C3, 1'b1);
        wait_done();
        check("t4_runs", 32'(run_count), 32'd3);
        check("t4_pass", 32'(session_pass), 32'd1);

        // 5: reset during WAIT_END of run 2
        pulse_go();
        respond(16'hA5C3, 1'b1);
        wait_pulse();
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_cleared("t5_rst");
        @(negedge clock); reset = 1'b1;
        pulse_go();
        check("t5_restart_runs", 32'(run_count), 32'd0);
        check("t5_restart_busy", 32'(busy), 32'd1);
        repeat (3) respond(16'hA5C3, 1'b1);
        wait_done();
        check("t5_runs", 32'(run_count), 32'd3);
        check("t5_pass", 32'(session_pass), 32'd1);

`ifdef BIST_CONSISTENCY_CHECK_EN
        // 6: signatures drift between runs
        pulse_go();
        check("t6_mism_cleared", 32'(sig_mismatch), 32'd0);
        respond(16'h1234, 1'b1);
        respond(16'h1234, 1'b1);
        @(negedge clock);
        check("t6_mism_early", 32'(sig_mismatch), 32'd0);
        respond(16'h1235, 1'b1);
        wait_done();
        check("t6_mism", 32'(sig_mismatch), 32'd1);
        check("t6_fails", 32'(fail_count), 32'd3);
        check("t6_pass", 32'(session_pass), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
